// File: rtl/sram_line_ctrl.sv
// Cache-side responder: 64-bit line refills / 32-bit word stores over a 16-bit async SRAM.
// Latency: read 1+4*ACCESS_CYC, write 1+2*ACCESS_CYC; ready low throughout, high in IDLE (no request) or DONE.
module sram_line_ctrl #(
    parameter int ACCESS_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    output logic [63:0] rdata,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam int CW = (ACCESS_CYC > 2) ? $clog2(ACCESS_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCESS_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [17:0]   addr_q;
    logic [31:0]   wdata_q;
    logic          last_cyc;
    logic          unused_addr_bits;

    // Only halfword address bits [18:1] reach the SRAM.
    assign unused_addr_bits = ^{address[31:19], address[0]};

    assign last_cyc = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= 2'd0;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    idx <= 2'd0;
                    cnt <= '0;
                    if (wr_en) begin
                        addr_q  <= address[18:1];
                        wdata_q <= wdata;
                        state   <= WRITE;
                    end else if (rd_en) begin
                        addr_q <= address[18:1];
                        state  <= READ;
                    end
                end
                READ: begin
                    if (last_cyc) begin
                        rdata[{idx, 4'b0000} +: 16] <= sram_dq_in;
                        cnt <= '0;
                        if (idx == 2'd3) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (last_cyc) begin
                        cnt <= '0;
                        if (idx == 2'd1) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // SRAM pins decode straight from registered state, so a reset edge releases the bus at once.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        case (state)
            READ: begin
                sram_addr = {addr_q[17:2], idx};
            end
            WRITE: begin
                sram_addr   = {addr_q[17:1], idx[0]};
                sram_dq_out = idx[0] ? wdata_q[31:16] : wdata_q[15:0];
                sram_dq_oe  = 1'b1;
                // Last cycle of each access keeps address/data stable after the write strobe.
                sram_we_n   = last_cyc;
            end
            default: begin
            end
        endcase
    end

    assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

endmodule

// File: tb/tb_sram_line_ctrl.sv
// Directed bench for sram_line_ctrl with a behavioural async SRAM model.
module tb_sram_line_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [63:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    logic [15:0] mem [0:262143];

    int pass_cnt  = 0;
    int total_cnt = 0;

    int          low_cnt;
    logic [17:0] addr_log [$];
    logic [15:0] dq_log   [$];
    logic        we_log   [$];
    logic        oe_log   [$];

    localparam logic [63:0] LINE_A = 64'h4444_3333_2222_1111;
    localparam logic [63:0] LINE_B = 64'hDDDD_CCCC_BBBB_AAAA;

    sram_line_ctrl #(.ACCESS_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    always #5 clk = ~clk;

    assign sram_dq_in = mem[sram_addr];

    always @(posedge clk) begin
        if (sram_we_n === 1'b0 && sram_dq_oe === 1'b1) mem[sram_addr] <= sram_dq_out;
    end

    // Starts from a negedge with the DUT in IDLE; logs every ready-low cycle (index 0 = IDLE cycle).
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input bit hold, input logic [31:0] mid_a);
        rd_en = rd; wr_en = wr; address = a; wdata = d;
        low_cnt = 0;
        addr_log.delete(); dq_log.delete(); we_log.delete(); oe_log.delete();
        #1;
        while (ready !== 1'b1 && low_cnt < 100) begin
            addr_log.push_back(sram_addr);
            dq_log.push_back(sram_dq_out);
            we_log.push_back(sram_we_n);
            oe_log.push_back(sram_dq_oe);
            low_cnt++;
            if (low_cnt == 3) address = mid_a;
            @(negedge clk);
        end
        if (!hold) begin
            rd_en = 1'b0; wr_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = '0; wdata = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else pass_cnt++;
        total_cnt++; if (sram_we_n !== 1'b1) $display("FAIL reset_we_n got %b want 1", sram_we_n); else pass_cnt++;
        total_cnt++; if (sram_dq_oe !== 1'b0) $display("FAIL reset_dq_oe got %b want 0", sram_dq_oe); else pass_cnt++;
        total_cnt++; if (rdata !== 64'h0) $display("FAIL reset_rdata got %h want 0", rdata); else pass_cnt++;
        total_cnt++; if (sram_addr !== 18'h0) $display("FAIL reset_addr got %h want 0", sram_addr); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_read_seq(input string name, input logic [17:0] base, input logic [63:0] line);
        bit ok;
        total_cnt++; if (low_cnt !== 9) $display("FAIL %s_latency got %0d want 9", name, low_cnt); else pass_cnt++;
        ok = (low_cnt == 9);
        for (int i = 1; i < 9 && ok; i++) begin
            if (addr_log[i] !== base + 18'((i - 1) / 2) || we_log[i] !== 1'b1 || oe_log[i] !== 1'b0) begin
                ok = 1'b0;
                $display("FAIL %s_bus cyc %0d got addr %h we_n %b oe %b want addr %h we_n 1 oe 0",
                         name, i, addr_log[i], we_log[i], oe_log[i], base + 18'((i - 1) / 2));
            end
        end
        total_cnt++; if (ok) pass_cnt++;
        total_cnt++; if (rdata !== line) $display("FAIL %s_rdata got %h want %h", name, rdata, line); else pass_cnt++;
    endtask

    task automatic check_write_seq(input string name, input logic [17:0] a0, input logic [31:0] d);
        logic [17:0] exp_a  [4];
        logic [15:0] exp_dq [4];
        logic        exp_we [4];
        bit ok;
        exp_a  = '{a0, a0, a0 + 18'd1, a0 + 18'd1};
        exp_dq = '{d[15:0], d[15:0], d[31:16], d[31:16]};
        exp_we = '{1'b0, 1'b1, 1'b0, 1'b1};
        total_cnt++; if (low_cnt !== 5) $display("FAIL %s_latency got %0d want 5", name, low_cnt); else pass_cnt++;
        ok = (low_cnt == 5);
        for (int i = 1; i < 5 && ok; i++) begin
            if (addr_log[i] !== exp_a[i-1] || dq_log[i] !== exp_dq[i-1] ||
                we_log[i] !== exp_we[i-1] || oe_log[i] !== 1'b1) begin
                ok = 1'b0;
                $display("FAIL %s_bus cyc %0d got addr %h dq %h we_n %b oe %b want addr %h dq %h we_n %b oe 1",
                         name, i, addr_log[i], dq_log[i], we_log[i], oe_log[i], exp_a[i-1], exp_dq[i-1], exp_we[i-1]);
            end
        end
        total_cnt++; if (ok) pass_cnt++;
        total_cnt++;
        if (mem[a0] !== d[15:0] || mem[a0 + 18'd1] !== d[31:16])
            $display("FAIL %s_mem got %h_%h want %h", name, mem[a0 + 18'd1], mem[a0], d);
        else pass_cnt++;
    endtask

    task automatic test_read;
        run_req(1'b1, 1'b0, 32'h0000_0408, 32'h0, 1'b0, 32'h0000_0408);
        check_read_seq("read", 18'h204, LINE_A);
    endtask

    task automatic test_write;
        run_req(1'b0, 1'b1, 32'h0000_0014, 32'hDEAD_BEEF, 1'b0, 32'h0000_0014);
        check_write_seq("write", 18'h00A, 32'hDEAD_BEEF);
        total_cnt++; if (rdata !== LINE_A) $display("FAIL write_rdata got %h want %h", rdata, LINE_A); else pass_cnt++;
    endtask

    task automatic test_both;
        run_req(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, 1'b0, 32'h0000_0020);
        check_write_seq("both", 18'h010, 32'h1234_5678);
        total_cnt++; if (rdata !== LINE_A) $display("FAIL both_rdata got %h want %h", rdata, LINE_A); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        // Address moves to the second line mid-read; the first read must not follow it.
        run_req(1'b1, 1'b0, 32'h0000_0408, 32'h0, 1'b1, 32'h0000_0600);
        check_read_seq("b2b_first", 18'h204, LINE_A);
        @(negedge clk);
        total_cnt++; if (ready !== 1'b0) $display("FAIL b2b_idle_ready got %b want 0", ready); else pass_cnt++;
        run_req(1'b1, 1'b0, 32'h0000_0600, 32'h0, 1'b0, 32'h0000_0600);
        check_read_seq("b2b_second", 18'h300, LINE_B);
    endtask

    task automatic test_reset_mid_write;
        rd_en = 1'b0; wr_en = 1'b1; address = 32'h0000_0014; wdata = 32'hCAFE_F00D;
        @(negedge clk); @(negedge clk); @(negedge clk);
        total_cnt++;
        if (sram_addr !== 18'h00B || sram_we_n !== 1'b0)
            $display("FAIL rstmid_idx1 got addr %h we_n %b want addr 00b we_n 0", sram_addr, sram_we_n);
        else pass_cnt++;
        rst = 1'b1; wr_en = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || ready !== 1'b1)
            $display("FAIL rstmid_abort got we_n %b oe %b ready %b want 1 0 1", sram_we_n, sram_dq_oe, ready);
        else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        run_req(1'b1, 1'b0, 32'h0000_0408, 32'h0, 1'b0, 32'h0000_0408);
        check_read_seq("rstmid_read", 18'h204, LINE_A);
    endtask

    initial begin
        mem[18'h204] = 16'h1111; mem[18'h205] = 16'h2222;
        mem[18'h206] = 16'h3333; mem[18'h207] = 16'h4444;
        mem[18'h300] = 16'hAAAA; mem[18'h301] = 16'hBBBB;
        mem[18'h302] = 16'hCCCC; mem[18'h303] = 16'hDDDD;
        test_reset();
        test_read();
        test_write();
        test_both();
        test_back_to_back();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
